// File: rtl/pdp8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdp8_pkg                                                                 |
// | Shared widths, arbiter state and requester-id encodings.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pdp8_pkg;

    localparam int ADDR_WIDTH       = 12;
    localparam int DATA_WIDTH       = 12;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IFU  = 1'b0,
        REQ_EXEC = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Two-requester (IFU, EXEC) arbiter onto one memory port, 3-cycle access. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rd_valid,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_gnt,
    output logic                  exec_rd_valid,
    output logic                  exec_wr_done,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  proto_err
);

    localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_LIMIT);

    arb_state_t            r_state;
    req_id_t               r_owner;
    logic [2:0]            r_starve;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_ifu_rd_valid;
    logic                  r_exec_rd_valid;
    logic                  r_exec_wr_done;
    logic [DATA_WIDTH-1:0] r_ifu_rd_data;
    logic [DATA_WIDTH-1:0] r_exec_rd_data;
    logic                  r_proto_err;

    logic w_idle;
    logic w_ifu_win;
    logic w_exec_win;
    logic w_exec_we;

    // A starved IFU overrides the normal write > read > fetch order.
    always_comb begin
        w_ifu_win  = 1'b0;
        w_exec_win = 1'b0;
        w_exec_we  = 1'b0;
        if (ifu_rd_req && (r_starve == c_STARVE_MAX)) begin
            w_ifu_win = 1'b1;
        end else if (exec_wr_req) begin
            w_exec_win = 1'b1;
            w_exec_we  = 1'b1;
        end else if (exec_rd_req) begin
            w_exec_win = 1'b1;
        end else if (ifu_rd_req) begin
            w_ifu_win = 1'b1;
        end
    end

    assign w_idle   = (r_state == ST_IDLE);
    assign ifu_gnt  = w_idle & w_ifu_win;
    assign exec_gnt = w_idle & w_exec_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_owner         <= REQ_IFU;
            r_starve        <= 3'd0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_ifu_rd_valid  <= 1'b0;
            r_exec_rd_valid <= 1'b0;
            r_exec_wr_done  <= 1'b0;
            r_ifu_rd_data   <= '0;
            r_exec_rd_data  <= '0;
            r_proto_err     <= 1'b0;
        end else begin
            if (!ifu_rd_req || ifu_gnt) begin
                r_starve <= 3'd0;
            end else if (exec_gnt && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + 3'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (exec_rd_req && exec_wr_req) begin
                        r_proto_err <= 1'b1;
                    end
                    if (w_ifu_win || w_exec_win) begin
                        r_owner     <= w_ifu_win ? REQ_IFU : REQ_EXEC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_exec_we;
                        r_mem_addr  <= w_ifu_win ? ifu_rd_addr : exec_addr;
                        r_mem_wdata <= w_exec_we ? exec_wr_data : '0;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_mem_we) begin
                        if (r_owner == REQ_IFU) begin
                            r_ifu_rd_data <= mem_rdata;
                        end else begin
                            r_exec_rd_data <= mem_rdata;
                        end
                    end
                    r_ifu_rd_valid  <= (r_owner == REQ_IFU);
                    r_exec_rd_valid <= (r_owner == REQ_EXEC) && !r_mem_we;
                    r_exec_wr_done  <= (r_owner == REQ_EXEC) && r_mem_we;
                    r_mem_req       <= 1'b0;
                    r_mem_we        <= 1'b0;
                    r_mem_addr      <= '0;
                    r_mem_wdata     <= '0;
                    r_state         <= ST_RESP;
                end
                ST_RESP: begin
                    r_ifu_rd_valid  <= 1'b0;
                    r_exec_rd_valid <= 1'b0;
                    r_exec_wr_done  <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ifu_rd_valid  = r_ifu_rd_valid;
    assign ifu_rd_data   = r_ifu_rd_data;
    assign exec_rd_valid = r_exec_rd_valid;
    assign exec_wr_done  = r_exec_wr_done;
    assign exec_rd_data  = r_exec_rd_data;
    assign mem_req       = r_mem_req;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign proto_err     = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter                                                           |
// | Directed-vector bench for mem_arbiter with a behavioural memory.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic        ifu_gnt;
    logic        ifu_rd_valid;
    logic [11:0] ifu_rd_data;
    logic        exec_rd_req;
    logic        exec_wr_req;
    logic [11:0] exec_addr;
    logic [11:0] exec_wr_data;
    logic        exec_gnt;
    logic        exec_rd_valid;
    logic        exec_wr_done;
    logic [11:0] exec_rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        proto_err;

    logic [11:0] mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [11:0] pl_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ifu_rd_req   (ifu_rd_req),
        .ifu_rd_addr  (ifu_rd_addr),
        .ifu_gnt      (ifu_gnt),
        .ifu_rd_valid (ifu_rd_valid),
        .ifu_rd_data  (ifu_rd_data),
        .exec_rd_req  (exec_rd_req),
        .exec_wr_req  (exec_wr_req),
        .exec_addr    (exec_addr),
        .exec_wr_data (exec_wr_data),
        .exec_gnt     (exec_gnt),
        .exec_rd_valid(exec_rd_valid),
        .exec_wr_done (exec_wr_done),
        .exec_rd_data (exec_rd_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_req && mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifu_rd_req = 1'b0; ifu_rd_addr = '0;
        exec_rd_req = 1'b0; exec_wr_req = 1'b0;
        exec_addr = '0; exec_wr_data = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(12'o200, 12'o7402);
        preload(12'o201, 12'o0017);
        preload(12'o300, 12'o4321);
        preload(12'o301, 12'o1111);
        preload(12'o050, 12'o0000);

        // Reset state
        smp();
        chk("rst_gnt",   {30'd0, ifu_gnt, exec_gnt}, 32'd0);
        chk("rst_mem",   {19'd0, mem_req, mem_we, mem_addr}, 32'd0);
        chk("rst_pulse", {29'd0, ifu_rd_valid, exec_rd_valid, exec_wr_done}, 32'd0);
        chk("rst_data",  {8'd0, ifu_rd_data, exec_rd_data}, 32'd0);
        chk("rst_perr",  32'(proto_err), 32'd0);
        step();
        reset = 1'b0;

        // IFU read 0o200
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        smp();
        chk("t1_ifu_gnt",  32'(ifu_gnt), 32'd1);
        chk("t1_exec_gnt", 32'(exec_gnt), 32'd0);
        step();
        ifu_rd_req = 1'b0;
        smp();
        chk("t1_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'o200);
        chk("t1_mem_we",   32'(mem_we), 32'd0);
        chk("t1_early_vld", 32'(ifu_rd_valid), 32'd0);
        step();
        smp();
        chk("t1_valid",    32'(ifu_rd_valid), 32'd1);
        chk("t1_data",     32'(ifu_rd_data), 32'o7402);
        chk("t1_resp_req", 32'(mem_req), 32'd0);
        step();

        // IFU read vs EXEC write in the same cycle
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o201;
        exec_wr_req = 1'b1; exec_addr = 12'o050; exec_wr_data = 12'o1234;
        smp();
        chk("t2_exec_gnt", 32'(exec_gnt), 32'd1);
        chk("t2_ifu_gnt",  32'(ifu_gnt), 32'd0);
        step();
        exec_wr_req = 1'b0;
        smp();
        chk("t2_mem",      {6'd0, mem_req, mem_we, mem_addr, mem_wdata}, {6'd0, 2'b11, 12'o050, 12'o1234});
        chk("t2_acc_gnt",  32'(ifu_gnt), 32'd0);
        step();
        smp();
        chk("t2_pulses",   {29'd0, ifu_rd_valid, exec_rd_valid, exec_wr_done}, 32'd1);
        chk("t2_mem_wr",   32'(mem[12'o050]), 32'o1234);
        step();
        smp();
        chk("t2_ifu_gnt2", 32'(ifu_gnt), 32'd1);
        step();
        ifu_rd_req = 1'b0;
        step();
        smp();
        chk("t2_ifu_data", 32'(ifu_rd_data), 32'o0017);
        step();

        // Starvation: EXEC read and IFU read held continuously
        exec_rd_req = 1'b1; exec_addr = 12'o300;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o301;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk($sformatf("t3_gnt%0d", i), {30'd0, ifu_gnt, exec_gnt},
                (i == 3) ? 32'd2 : 32'd1);
            step();
            if (i == 4) begin
                exec_rd_req = 1'b0; ifu_rd_req = 1'b0;
            end
            smp();
            chk($sformatf("t3_addr%0d", i), 32'(mem_addr), (i == 3) ? 32'o301 : 32'o300);
            step();
            smp();
            if (i == 3)
                chk("t3_ifu_data", {31'd0, ifu_rd_valid, ifu_rd_data}, {19'd0, 1'b1, 12'o1111});
            else
                chk($sformatf("t3_exec_data%0d", i), {19'd0, exec_rd_valid, exec_rd_data},
                    {19'd0, 1'b1, 12'o4321});
            step();
        end

        // Both EXEC read and write at once
        exec_rd_req = 1'b1; exec_wr_req = 1'b1; exec_addr = 12'o100; exec_wr_data = 12'o0555;
        smp();
        chk("t4_gnt", {30'd0, ifu_gnt, exec_gnt}, 32'd1);
        step();
        exec_rd_req = 1'b0; exec_wr_req = 1'b0;
        smp();
        chk("t4_mem", {18'd0, mem_we, mem_addr, 1'b0}, {18'd0, 1'b1, 12'o100, 1'b0});
        step();
        smp();
        chk("t4_pulses", {29'd0, ifu_rd_valid, exec_rd_valid, exec_wr_done}, 32'd1);
        chk("t4_perr",   32'(proto_err), 32'd1);
        step();
        step();
        smp();
        chk("t4_perr_sticky", 32'(proto_err), 32'd1);
        step();

        // Reset during ACCESS
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        step();
        ifu_rd_req = 1'b0;
        smp();
        chk("t5_access", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_mem",  {19'd0, mem_req, mem_we, mem_addr}, 32'd0);
        chk("t5_rst_data", {8'd0, ifu_rd_data, exec_rd_data}, 32'd0);
        chk("t5_rst_perr", 32'(proto_err), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("t5_quiet%0d", i),
                {28'd0, ifu_rd_valid, exec_rd_valid, exec_wr_done, mem_req}, 32'd0);
            step();
        end
        exec_rd_req = 1'b1; exec_addr = 12'o300;
        smp();
        chk("t5_idle_gnt", 32'(exec_gnt), 32'd1);
        step();
        exec_rd_req = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
